// File: rtl/ysyx_axi_rd_sched_if.sv
// Read-channel bundle for ysyx_axi_rd_sched: requester ports m0 (IFU), m1 (LSU) and the io_master read port.
// slave is the scheduler's view; master is the environment that issues requests and models io_master.
interface ysyx_axi_rd_sched_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic [ADDR_W-1:0] m0_araddr;
    logic [7:0]        m0_arlen;
    logic [2:0]        m0_arsize;
    logic              m0_arvalid;
    logic              m0_arready_o;
    logic [DATA_W-1:0] m0_rdata_o;
    logic [1:0]        m0_rresp_o;
    logic              m0_rlast_o;
    logic              m0_rvalid_o;
    logic              m0_rready;

    logic [ADDR_W-1:0] m1_araddr;
    logic [7:0]        m1_arlen;
    logic [2:0]        m1_arsize;
    logic              m1_arvalid;
    logic              m1_arready_o;
    logic [DATA_W-1:0] m1_rdata_o;
    logic [1:0]        m1_rresp_o;
    logic              m1_rlast_o;
    logic              m1_rvalid_o;
    logic              m1_rready;

    logic [ADDR_W-1:0] s_araddr;
    logic [7:0]        s_arlen;
    logic [2:0]        s_arsize;
    logic [3:0]        s_arid;
    logic              s_arvalid;
    logic              s_arready;
    logic [DATA_W-1:0] s_rdata;
    logic [1:0]        s_rresp;
    logic              s_rlast;
    logic              s_rvalid;
    logic              s_rready_o;

    modport slave (
        input  m0_araddr, m0_arlen, m0_arsize, m0_arvalid, m0_rready,
        output m0_arready_o, m0_rdata_o, m0_rresp_o, m0_rlast_o, m0_rvalid_o,
        input  m1_araddr, m1_arlen, m1_arsize, m1_arvalid, m1_rready,
        output m1_arready_o, m1_rdata_o, m1_rresp_o, m1_rlast_o, m1_rvalid_o,
        output s_araddr, s_arlen, s_arsize, s_arid, s_arvalid, s_rready_o,
        input  s_arready, s_rdata, s_rresp, s_rlast, s_rvalid
    );

    modport master (
        output m0_araddr, m0_arlen, m0_arsize, m0_arvalid, m0_rready,
        input  m0_arready_o, m0_rdata_o, m0_rresp_o, m0_rlast_o, m0_rvalid_o,
        output m1_araddr, m1_arlen, m1_arsize, m1_arvalid, m1_rready,
        input  m1_arready_o, m1_rdata_o, m1_rresp_o, m1_rlast_o, m1_rvalid_o,
        input  s_araddr, s_arlen, s_arsize, s_arid, s_arvalid, s_rready_o,
        output s_arready, s_rdata, s_rresp, s_rlast, s_rvalid
    );
endinterface

// File: rtl/ysyx_axi_rd_sched.sv
// Two-requester AXI4 read scheduler (m1 LSU over m0 IFU), one outstanding burst, beat-count checking.
// Define YSYX_ARB_AGING_EN to force an m0 grant after AGE_MAX consecutive m1 grants while m0 waits.
module ysyx_axi_rd_sched #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
`ifdef YSYX_ARB_AGING_EN
    , parameter int AGE_MAX = 4
`endif
) (
    input  logic                clk,
    input  logic                rst,
    ysyx_axi_rd_sched_if.slave  bus,
    output logic                busy_o,
    output logic                err_o
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t            state, state_nxt;
    logic              owner;
    logic [7:0]        beat_cnt;
    logic              err;
    logic [ADDR_W-1:0] araddr_p0;
    logic [7:0]        arlen_p0;
    logic [2:0]        arsize_p0;
    logic              idle_ok, grant_m0, grant_m1, force_m0;
    logic              owner_rready, beat_hs;

    // Arbitration only happens in IDLE and never while reset is held.
    assign idle_ok  = (state == IDLE) && !rst;
    assign grant_m1 = idle_ok && bus.m1_arvalid && !(force_m0 && bus.m0_arvalid);
    assign grant_m0 = idle_ok && bus.m0_arvalid && !grant_m1;

`ifdef YSYX_ARB_AGING_EN
    logic [2:0] age;

    assign force_m0 = (age == 3'(AGE_MAX));

    always_ff @(posedge clk) begin
        if (rst)
            age <= 3'd0;
        else if (grant_m0)
            age <= 3'd0;
        else if (grant_m1 && bus.m0_arvalid)
            age <= age + 3'd1;
    end
`else
    assign force_m0 = 1'b0;
`endif

    assign owner_rready = owner ? bus.m1_rready : bus.m0_rready;
    assign beat_hs      = (state == DATA) && bus.s_rvalid && owner_rready;

    assign bus.s_araddr = araddr_p0;
    assign bus.s_arlen  = arlen_p0;
    assign bus.s_arsize = arsize_p0;
    assign bus.s_arid   = {3'b000, owner};

    assign busy_o = (state != IDLE);
    assign err_o  = err;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt        = state;
        bus.m0_arready_o = grant_m0;
        bus.m1_arready_o = grant_m1;
        bus.m0_rvalid_o  = 1'b0;
        bus.m0_rdata_o   = {DATA_W{1'b0}};
        bus.m0_rresp_o   = 2'b00;
        bus.m0_rlast_o   = 1'b0;
        bus.m1_rvalid_o  = 1'b0;
        bus.m1_rdata_o   = {DATA_W{1'b0}};
        bus.m1_rresp_o   = 2'b00;
        bus.m1_rlast_o   = 1'b0;
        bus.s_arvalid    = 1'b0;
        bus.s_rready_o   = 1'b0;
        case (state)
            IDLE: begin
                if (grant_m0 || grant_m1)
                    state_nxt = ADDR;
            end
            ADDR: begin
                bus.s_arvalid = 1'b1;
                if (bus.s_arready)
                    state_nxt = DATA;
            end
            DATA: begin
                bus.s_rready_o = owner_rready;
                if (owner) begin
                    bus.m1_rvalid_o = bus.s_rvalid;
                    bus.m1_rdata_o  = bus.s_rdata;
                    bus.m1_rresp_o  = bus.s_rresp;
                    bus.m1_rlast_o  = bus.s_rlast;
                end else begin
                    bus.m0_rvalid_o = bus.s_rvalid;
                    bus.m0_rdata_o  = bus.s_rdata;
                    bus.m0_rresp_o  = bus.s_rresp;
                    bus.m0_rlast_o  = bus.s_rlast;
                end
                if (beat_hs && bus.s_rlast)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Control: owner, beat counter and the sticky length-mismatch flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner    <= 1'b0;
            beat_cnt <= 8'd0;
            err      <= 1'b0;
        end else begin
            if (grant_m0 || grant_m1)
                owner <= grant_m1;
            if ((state == ADDR) && bus.s_arready)
                beat_cnt <= 8'd0;
            else if (beat_hs && (beat_cnt != 8'hFF))
                beat_cnt <= beat_cnt + 8'd1;
            if (beat_hs && (bus.s_rlast != (beat_cnt == arlen_p0)))
                err <= 1'b1;
        end
    end

    // Request fields are captured at grant and held for the whole transaction.
    always_ff @(posedge clk) begin
        if (grant_m1) begin
            araddr_p0 <= bus.m1_araddr;
            arlen_p0  <= bus.m1_arlen;
            arsize_p0 <= bus.m1_arsize;
        end else if (grant_m0) begin
            araddr_p0 <= bus.m0_araddr;
            arlen_p0  <= bus.m0_arlen;
            arsize_p0 <= bus.m0_arsize;
        end
    end
endmodule

// File: tb/tb_ysyx_axi_rd_sched.sv
// Directed bench for ysyx_axi_rd_sched: single beat, priority, bursts, error flag, aging and reset.
module tb_ysyx_axi_rd_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy_o, err_o;
    int   n_tests = 0;
    int   n_fail  = 0;

    ysyx_axi_rd_sched_if #(.ADDR_W(32), .DATA_W(64)) bus ();

    ysyx_axi_rd_sched dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .busy_o (busy_o),
        .err_o  (err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, want finish before 500000");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.m0_araddr = '0; bus.m0_arlen = '0; bus.m0_arsize = '0; bus.m0_arvalid = 1'b0; bus.m0_rready = 1'b0;
        bus.m1_araddr = '0; bus.m1_arlen = '0; bus.m1_arsize = '0; bus.m1_arvalid = 1'b0; bus.m1_rready = 1'b0;
        bus.s_arready = 1'b0; bus.s_rdata = '0; bus.s_rresp = '0; bus.s_rlast = 1'b0; bus.s_rvalid = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Issues one request from the given requester and completes the AR handshake; returns in DATA.
    task automatic request(input bit who, input logic [31:0] addr, input logic [7:0] len);
        if (who) begin
            bus.m1_arvalid = 1'b1; bus.m1_araddr = addr; bus.m1_arlen = len; bus.m1_arsize = 3'd3;
        end else begin
            bus.m0_arvalid = 1'b1; bus.m0_araddr = addr; bus.m0_arlen = len; bus.m0_arsize = 3'd3;
        end
        tick();
        if (who) bus.m1_arvalid = 1'b0;
        else     bus.m0_arvalid = 1'b0;
        bus.s_arready = 1'b1;
        tick();
        bus.s_arready = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        bus.m0_arvalid = 1'b1;
        bus.m1_arvalid = 1'b1;
        tick();
        tick();
        n_tests++;
        if (bus.m0_arready_o !== 1'b0 || bus.m1_arready_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_arready: got m0=%b m1=%b, want 0 0", bus.m0_arready_o, bus.m1_arready_o);
        end
        n_tests++;
        if (busy_o !== 1'b0 || err_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_status: got busy=%b err=%b, want 0 0", busy_o, err_o);
        end
        n_tests++;
        if (bus.s_arvalid !== 1'b0 || bus.s_rready_o !== 1'b0 || bus.m0_rvalid_o !== 1'b0 || bus.m1_rvalid_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_valids: got arv=%b rrdy=%b rv0=%b rv1=%b, want 0", bus.s_arvalid,
                               bus.s_rready_o, bus.m0_rvalid_o, bus.m1_rvalid_o);
        end
        clear_inputs();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_m0_single();
        bus.m0_arvalid = 1'b1; bus.m0_araddr = 32'h3000_0000; bus.m0_arlen = 8'd0; bus.m0_arsize = 3'd3;
        bus.m0_rready = 1'b1;
        #1;
        n_tests++;
        if (bus.m0_arready_o !== 1'b1 || bus.s_arvalid !== 1'b0) begin
            n_fail++; $display("FAIL m0_accept: got arready=%b s_arvalid=%b, want 1 0", bus.m0_arready_o, bus.s_arvalid);
        end
        tick();
        bus.m0_arvalid = 1'b0;
        #1;
        n_tests++;
        if (bus.s_arvalid !== 1'b1 || bus.s_araddr !== 32'h3000_0000 || bus.s_arid !== 4'd0 || bus.s_arlen !== 8'd0) begin
            n_fail++; $display("FAIL m0_ar: got v=%b addr=%h id=%0d len=%0d, want 1 30000000 0 0", bus.s_arvalid,
                               bus.s_araddr, bus.s_arid, bus.s_arlen);
        end
        bus.s_arready = 1'b1;
        tick();
        bus.s_arready = 1'b0;
        bus.s_rvalid = 1'b1; bus.s_rdata = 64'hDEAD; bus.s_rlast = 1'b1; bus.s_rresp = 2'b00;
        #1;
        n_tests++;
        if (bus.m0_rvalid_o !== 1'b1 || bus.m0_rdata_o !== 64'hDEAD || bus.m0_rlast_o !== 1'b1 || bus.s_rready_o !== 1'b1) begin
            n_fail++; $display("FAIL m0_beat: got rv=%b data=%h last=%b rrdy=%b, want 1 dead 1 1", bus.m0_rvalid_o,
                               bus.m0_rdata_o, bus.m0_rlast_o, bus.s_rready_o);
        end
        n_tests++;
        if (bus.m1_rvalid_o !== 1'b0 || bus.s_arvalid !== 1'b0) begin
            n_fail++; $display("FAIL m0_other: got m1_rvalid=%b s_arvalid=%b, want 0 0", bus.m1_rvalid_o, bus.s_arvalid);
        end
        tick();
        bus.s_rvalid = 1'b0; bus.s_rlast = 1'b0;
        n_tests++;
        if (busy_o !== 1'b0 || err_o !== 1'b0) begin
            n_fail++; $display("FAIL m0_done: got busy=%b err=%b, want 0 0", busy_o, err_o);
        end
        clear_inputs();
    endtask

    task automatic test_priority();
        bus.m0_arvalid = 1'b1; bus.m0_araddr = 32'h0000_0100; bus.m0_arlen = 8'd0;
        bus.m1_arvalid = 1'b1; bus.m1_araddr = 32'h0000_0200; bus.m1_arlen = 8'd0;
        bus.m0_rready = 1'b1; bus.m1_rready = 1'b1;
        #1;
        n_tests++;
        if (bus.m1_arready_o !== 1'b1 || bus.m0_arready_o !== 1'b0) begin
            n_fail++; $display("FAIL prio_grant: got m1=%b m0=%b, want 1 0", bus.m1_arready_o, bus.m0_arready_o);
        end
        tick();
        bus.m1_arvalid = 1'b0;
        tick();
        n_tests++;
        if (bus.s_arvalid !== 1'b1 || bus.s_arid !== 4'd1 || bus.s_araddr !== 32'h0000_0200 || bus.m0_arready_o !== 1'b0) begin
            n_fail++; $display("FAIL prio_ar_hold: got v=%b id=%0d addr=%h m0rdy=%b, want 1 1 200 0", bus.s_arvalid,
                               bus.s_arid, bus.s_araddr, bus.m0_arready_o);
        end
        bus.s_arready = 1'b1;
        tick();
        bus.s_arready = 1'b0;
        bus.s_rvalid = 1'b1; bus.s_rdata = 64'h11; bus.s_rlast = 1'b1;
        #1;
        n_tests++;
        if (bus.m1_rdata_o !== 64'h11 || bus.m1_rvalid_o !== 1'b1 || bus.m0_rdata_o !== 64'h0 || bus.m0_rvalid_o !== 1'b0) begin
            n_fail++; $display("FAIL prio_route: got m1=%b/%h m0=%b/%h, want 1/11 0/0", bus.m1_rvalid_o, bus.m1_rdata_o,
                               bus.m0_rvalid_o, bus.m0_rdata_o);
        end
        n_tests++;
        if (bus.m0_arready_o !== 1'b0) begin
            n_fail++; $display("FAIL prio_overlap: got m0_arready=%b in last beat, want 0", bus.m0_arready_o);
        end
        tick();
        bus.s_rvalid = 1'b0; bus.s_rlast = 1'b0;
        #1;
        n_tests++;
        if (bus.m0_arready_o !== 1'b1) begin
            n_fail++; $display("FAIL prio_m0_next: got m0_arready=%b, want 1", bus.m0_arready_o);
        end
        tick();
        bus.m0_arvalid = 1'b0;
        n_tests++;
        if (bus.s_arid !== 4'd0 || bus.s_araddr !== 32'h0000_0100) begin
            n_fail++; $display("FAIL prio_m0_ar: got id=%0d addr=%h, want 0 100", bus.s_arid, bus.s_araddr);
        end
        bus.s_arready = 1'b1;
        tick();
        bus.s_arready = 1'b0;
        bus.s_rvalid = 1'b1; bus.s_rlast = 1'b1;
        tick();
        clear_inputs();
    endtask

    task automatic test_burst();
        int k = 0;
        bus.m1_rready = 1'b1;
        request(1'b1, 32'h8000_0040, 8'd3);
        for (int c = 0; c < 16 && k < 4; c++) begin
            bus.s_rvalid = 1'b1; bus.s_rdata = 64'hA0 + 64'(k); bus.s_rlast = (k == 3);
            bus.m1_rready = (c % 2 == 0);
            #1;
            n_tests++;
            if (bus.m1_rvalid_o !== 1'b1 || bus.m1_rdata_o !== 64'hA0 + 64'(k) || bus.m1_rlast_o !== (k == 3)) begin
                n_fail++; $display("FAIL burst_beat%0d: got rv=%b data=%h last=%b, want 1 %h %b", k, bus.m1_rvalid_o,
                                   bus.m1_rdata_o, bus.m1_rlast_o, 64'hA0 + 64'(k), (k == 3));
            end
            n_tests++;
            if (bus.s_rready_o !== bus.m1_rready || bus.m0_rvalid_o !== 1'b0) begin
                n_fail++; $display("FAIL burst_ready: got rrdy=%b m0rv=%b, want %b 0", bus.s_rready_o,
                                   bus.m0_rvalid_o, bus.m1_rready);
            end
            if (bus.m1_rready) k++;
            tick();
        end
        bus.s_rvalid = 1'b0; bus.s_rlast = 1'b0;
        n_tests++;
        if (k !== 4 || busy_o !== 1'b0 || err_o !== 1'b0) begin
            n_fail++; $display("FAIL burst_end: got beats=%0d busy=%b err=%b, want 4 0 0", k, busy_o, err_o);
        end
        clear_inputs();
    endtask

    task automatic test_rresp();
        bus.m0_rready = 1'b1;
        request(1'b0, 32'h100, 8'd1);
        bus.s_rvalid = 1'b1; bus.s_rresp = 2'b10; bus.s_rlast = 1'b0; bus.s_rdata = 64'h5;
        #1;
        n_tests++;
        if (bus.m0_rresp_o !== 2'b10) begin
            n_fail++; $display("FAIL rresp_fwd: got %b, want 10", bus.m0_rresp_o);
        end
        tick();
        n_tests++;
        if (busy_o !== 1'b1) begin
            n_fail++; $display("FAIL rresp_continue: got busy=%b, want 1", busy_o);
        end
        bus.s_rresp = 2'b00; bus.s_rlast = 1'b1;
        tick();
        bus.s_rvalid = 1'b0; bus.s_rlast = 1'b0;
        n_tests++;
        if (busy_o !== 1'b0 || err_o !== 1'b0) begin
            n_fail++; $display("FAIL rresp_end: got busy=%b err=%b, want 0 0", busy_o, err_o);
        end
        clear_inputs();
    endtask

    task automatic test_outside_beat();
        bus.s_rvalid = 1'b1; bus.s_rlast = 1'b1; bus.m0_rready = 1'b1; bus.m1_rready = 1'b1;
        #1;
        n_tests++;
        if (bus.s_rready_o !== 1'b0 || bus.m0_rvalid_o !== 1'b0 || bus.m1_rvalid_o !== 1'b0) begin
            n_fail++; $display("FAIL idle_beat: got rrdy=%b rv0=%b rv1=%b, want 0 0 0", bus.s_rready_o,
                               bus.m0_rvalid_o, bus.m1_rvalid_o);
        end
        tick();
        n_tests++;
        if (busy_o !== 1'b0 || err_o !== 1'b0) begin
            n_fail++; $display("FAIL idle_beat_state: got busy=%b err=%b, want 0 0", busy_o, err_o);
        end
        clear_inputs();
    endtask

    task automatic test_err();
        bus.m0_rready = 1'b1;
        request(1'b0, 32'h200, 8'd1);
        bus.s_rvalid = 1'b1; bus.s_rlast = 1'b1;
        tick();
        bus.s_rvalid = 1'b0; bus.s_rlast = 1'b0;
        n_tests++;
        if (err_o !== 1'b1 || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL err_early_last: got err=%b busy=%b, want 1 0", err_o, busy_o);
        end
        request(1'b0, 32'h208, 8'd0);
        bus.s_rvalid = 1'b1; bus.s_rlast = 1'b1;
        tick();
        bus.s_rvalid = 1'b0; bus.s_rlast = 1'b0;
        n_tests++;
        if (err_o !== 1'b1) begin
            n_fail++; $display("FAIL err_sticky: got err=%b, want 1", err_o);
        end
        pulse_reset();
        n_tests++;
        if (err_o !== 1'b0) begin
            n_fail++; $display("FAIL err_clear: got err=%b, want 0", err_o);
        end
        request(1'b0, 32'h210, 8'd0);
        bus.s_rvalid = 1'b1; bus.s_rlast = 1'b0;
        tick();
        n_tests++;
        if (err_o !== 1'b1 || busy_o !== 1'b1) begin
            n_fail++; $display("FAIL err_missing_last: got err=%b busy=%b, want 1 1", err_o, busy_o);
        end
        bus.s_rlast = 1'b1;
        tick();
        bus.s_rvalid = 1'b0; bus.s_rlast = 1'b0;
        n_tests++;
        if (busy_o !== 1'b0) begin
            n_fail++; $display("FAIL err_late_last: got busy=%b, want 0", busy_o);
        end
        clear_inputs();
        pulse_reset();
    endtask

    task automatic test_aging();
        bit seq[10];
        int ng = 0;
        bit exp_g;
        pulse_reset();
        bus.m0_arvalid = 1'b1; bus.m1_arvalid = 1'b1;
        bus.m0_rready = 1'b1; bus.m1_rready = 1'b1;
        bus.s_arready = 1'b1; bus.s_rvalid = 1'b1; bus.s_rlast = 1'b1;
        for (int c = 0; c < 40 && ng < 10; c++) begin
            #1;
            if (bus.m0_arready_o && bus.m1_arready_o) begin
                n_tests++; n_fail++;
                $display("FAIL aging_double: both arready high at cycle %0d, want one", c);
            end else if (bus.m0_arready_o || bus.m1_arready_o) begin
                seq[ng] = bus.m1_arready_o;
                ng++;
            end
            tick();
        end
        clear_inputs();
        n_tests++;
        if (ng !== 10) begin
            n_fail++; $display("FAIL aging_count: got %0d grants, want 10", ng);
        end
        for (int i = 0; i < ng; i++) begin
`ifdef YSYX_ARB_AGING_EN
            exp_g = (i % 5 != 4);
`else
            exp_g = 1'b1;
`endif
            n_tests++;
            if (seq[i] !== exp_g) begin
                n_fail++; $display("FAIL aging_grant%0d: got m%0d, want m%0d", i, seq[i], exp_g);
            end
        end
        tick();
        pulse_reset();
    endtask

    task automatic test_rst_mid();
        bus.m1_rready = 1'b1;
        request(1'b1, 32'h400, 8'd0);
        bus.s_rvalid = 1'b1; bus.s_rlast = 1'b0;
        tick();
        n_tests++;
        if (busy_o !== 1'b1 || err_o !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_setup: got busy=%b err=%b, want 1 1", busy_o, err_o);
        end
        rst = 1'b1;
        tick();
        n_tests++;
        if (busy_o !== 1'b0 || err_o !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_state: got busy=%b err=%b, want 0 0", busy_o, err_o);
        end
        n_tests++;
        if (bus.m1_rvalid_o !== 1'b0 || bus.s_rready_o !== 1'b0 || bus.s_arvalid !== 1'b0 || bus.m1_arready_o !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_valids: got rv1=%b rrdy=%b arv=%b ardy1=%b, want 0", bus.m1_rvalid_o,
                               bus.s_rready_o, bus.s_arvalid, bus.m1_arready_o);
        end
        rst = 1'b0;
        clear_inputs();
        tick();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_m0_single();
        test_priority();
        test_burst();
        test_rresp();
        test_outside_beat();
        test_err();
        test_aging();
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
